options_summary_builder: RTL and testbench
==========================================

Name: options_summary_builder

Overview:
- Downstream of the TCP options parser.
- Consumes the parser's stream of decoded option records (kind, length, value) for one segment.
- Accumulates them into a single per-segment summary (MSS, window scale, SACK-permitted, timestamps, error/unknown status).
- Hands the summary to the connection-state stage over a valid/ready handshake.

Parameters:
- DEFAULT_MSS, 536, MSS reported when no MSS option is present.
- MAX_WSCALE, 14, upper clamp for the window-scale shift count.
- UNK_CNT_W, 4, width of the saturating unknown-option counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opt_valid  in  1  record valid.
- opt_ready  out  1  block accepts a record.
- opt_kind  in  8  option kind byte.
- opt_len  in  8  option length byte as received (0 for kinds 0/1).
- opt_val0  in  32  first value word, right-aligned: MSS in [15:0], shift in [7:0], TSval in [31:0].
- opt_val1  in  32  second value word: TSecr; else don't-care.
- opt_last  in  1  last record of the segment.
- opt_err  in  1  parser flagged a malformed option area for this segment.
- sum_valid  out  1  summary valid.
- sum_ready  in  1  consumer accepts summary.
- sum_mss  out  16  MSS.
- sum_wscale  out  4  window shift, clamped.
- sum_ws_present  out  1  WS option seen.
- sum_sack_ok  out  1  SACK-permitted seen.
- sum_ts_present  out  1  timestamp option seen.
- sum_tsval  out  32  TSval.
- sum_tsecr  out  32  TSecr.
- sum_ws_clamped  out  1  received shift exceeded MAX_WSCALE.
- sum_unknown_cnt  out  UNK_CNT_W  unrecognised options, saturating.
- sum_error  out  1  any error for the segment.

Behaviour:
- Reset (async, any state, including mid-segment or while sum_valid is high):
  - state returns to COLLECT;
  - all accumulators are cleared;
  - sum_valid = 0; opt_ready = 0 during reset, then 1 in the first cycle after reset is released;
  - sum_mss = DEFAULT_MSS; all other sum_* outputs = 0.
- States: COLLECT, EMIT.
- COLLECT:
  - opt_ready = 1; a record is accepted when opt_valid & opt_ready.
- Accepted record, by kind:
  - 0 (EOL) and 1 (NOP): no field update.
  - 2 (MSS): requires len=4. Sets mss = opt_val0[15:0].
  - 3 (WS): requires len=3. shift = opt_val0[7:0].
    - If shift > MAX_WSCALE: wscale = MAX_WSCALE and ws_clamped = 1.
    - ws_present = 1.
  - 4 (SACK-perm): requires len=2. Sets sack_ok = 1.
  - 8 (TS): requires len=10. Sets tsval = opt_val0, tsecr = opt_val1, ts_present = 1.
  - Any other kind: unknown_cnt++, saturating at all-ones; no error.
- Error conditions. Each sets error = 1 and leaves the affected field unchanged:
  - length mismatch on kinds 2/3/4/8;
  - duplicate occurrence of kind 2, 3, 4 or 8 (first value wins);
  - opt_err high on any accepted record.
- Transition to EMIT:
  - Accepted record with opt_last = 1 moves the block to EMIT.
  - That record's updates are included in the summary.
  - sum_valid rises in the next cycle (1-cycle latency from the last accept).
- EMIT:
  - opt_ready = 0.
  - sum_* outputs are stable while sum_valid = 1 && sum_ready = 0.
  - On sum_valid & sum_ready: accumulators reset to reset values and the block returns to COLLECT.
  - opt_ready = 1 in the following cycle; no back-to-back accept in the handshake cycle.
- sum_* outputs are registered and reflect the accumulators; they are only meaningful while sum_valid = 1.
- Single-record segment (opt_last on the first record) is legal.
- An empty segment is not signalled by the parser; the parser always sends at least one EOL record with opt_last = 1.
- opt_* inputs are ignored while opt_valid = 0 or while in EMIT.

Test Plan:
1. Records MSS (len 4, val 1460), WS (len 3, val 7), SACK (len 2), TS (len 10, 0x11223344 / 0x55667788, last) with sum_ready=1 -> one cycle after last: sum_valid=1, mss=1460, wscale=7, ws_present=1, sack_ok=1, ts_present=1, tsval=0x11223344, tsecr=0x55667788, error=0, unknown_cnt=0.
2. Single EOL with last -> sum_valid=1, mss=536, all flags 0, unknown_cnt=0.
3. WS val 20, then MSS len 3 with last -> wscale=14, ws_clamped=1, mss=536, error=1.
4. MSS 1000, MSS 500, kind 30 ×17, last -> mss=1000, error=1, unknown_cnt=15 (saturated).
5. Hold sum_ready=0 for 5 cycles -> sum_* stable and opt_ready=0 throughout; then sum_ready=1 -> opt_ready=1 next cycle and the next segment sees cleared fields.
6. Assert rst while in EMIT, and separately after two records mid-segment -> sum_valid=0 immediately; the next segment's summary carries no values from the aborted segment.

Source files
------------

// File: rtl/options_summary_builder_if.sv
// Record stream from the options parser plus the per-segment summary handed downstream.
// Master side produces records and consumes summaries; slave side is the summary builder.
interface options_summary_builder_if #(
    parameter int unsigned UNK_CNT_W = 4
);
    logic                 opt_valid;
    logic                 opt_ready;
    logic [7:0]           opt_kind;
    logic [7:0]           opt_len;
    logic [31:0]          opt_val0;
    logic [31:0]          opt_val1;
    logic                 opt_last;
    logic                 opt_err;

    logic                 sum_valid;
    logic                 sum_ready;
    logic [15:0]          sum_mss;
    logic [3:0]           sum_wscale;
    logic                 sum_ws_present;
    logic                 sum_sack_ok;
    logic                 sum_ts_present;
    logic [31:0]          sum_tsval;
    logic [31:0]          sum_tsecr;
    logic                 sum_ws_clamped;
    logic [UNK_CNT_W-1:0] sum_unknown_cnt;
    logic                 sum_error;

    modport master (
        output opt_valid, opt_kind, opt_len, opt_val0, opt_val1, opt_last, opt_err,
        input  opt_ready,
        input  sum_valid, sum_mss, sum_wscale, sum_ws_present, sum_sack_ok, sum_ts_present,
               sum_tsval, sum_tsecr, sum_ws_clamped, sum_unknown_cnt, sum_error,
        output sum_ready
    );

    modport slave (
        input  opt_valid, opt_kind, opt_len, opt_val0, opt_val1, opt_last, opt_err,
        output opt_ready,
        output sum_valid, sum_mss, sum_wscale, sum_ws_present, sum_sack_ok, sum_ts_present,
               sum_tsval, sum_tsecr, sum_ws_clamped, sum_unknown_cnt, sum_error,
        input  sum_ready
    );
endinterface

// File: rtl/options_summary_builder.sv
// Folds one segment's decoded TCP option records into a summary; summary valid 1 cycle after the last record.
// Records are stalled (opt_ready=0) while a summary waits for sum_ready; accepts resume the cycle after handoff.
module options_summary_builder #(
    parameter int unsigned DEFAULT_MSS = 536,
    parameter int unsigned MAX_WSCALE  = 14,
    parameter int unsigned UNK_CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    options_summary_builder_if.slave bus
);
    localparam logic [15:0] MSS_RST = 16'(DEFAULT_MSS);
    localparam logic [7:0]  WS_MAX8 = 8'(MAX_WSCALE);
    localparam logic [3:0]  WS_MAX4 = 4'(MAX_WSCALE);

    typedef enum logic {COLLECT, EMIT} state_t;

    typedef struct packed {
        logic [15:0]          mss;
        logic                 mss_seen;
        logic [3:0]           wscale;
        logic                 ws_present;
        logic                 ws_clamped;
        logic                 sack_ok;
        logic                 ts_present;
        logic [31:0]          tsval;
        logic [31:0]          tsecr;
        logic [UNK_CNT_W-1:0] unknown_cnt;
        logic                 error;
    } acc_t;

    localparam acc_t ACC_RST = '{mss: MSS_RST, default: '0};

    state_t state_q, state_nxt;
    acc_t   acc_q, acc_nxt;
    logic   ready_q;
    logic   accept;

    assign accept = (state_q == COLLECT) && ready_q && bus.opt_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            ready_q <= 1'b0;
            acc_q   <= ACC_RST;
        end else begin
            state_q <= state_nxt;
            ready_q <= 1'b1;
            acc_q   <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        acc_nxt   = acc_q;
        if (state_q == EMIT && bus.sum_ready) begin
            state_nxt = COLLECT;
            acc_nxt   = ACC_RST;
        end
        if (accept) begin
            // A record inside a parser-flagged option area is untrusted: flag it and drop its contents.
            if (bus.opt_err) begin
                acc_nxt.error = 1'b1;
            end else begin
                case (bus.opt_kind)
                    8'd0, 8'd1: ;
                    8'd2: begin
                        if (bus.opt_len != 8'd4 || acc_q.mss_seen) begin
                            acc_nxt.error = 1'b1;
                        end else begin
                            acc_nxt.mss      = bus.opt_val0[15:0];
                            acc_nxt.mss_seen = 1'b1;
                        end
                    end
                    8'd3: begin
                        if (bus.opt_len != 8'd3 || acc_q.ws_present) begin
                            acc_nxt.error = 1'b1;
                        end else begin
                            acc_nxt.ws_present = 1'b1;
                            if (bus.opt_val0[7:0] > WS_MAX8) begin
                                acc_nxt.wscale     = WS_MAX4;
                                acc_nxt.ws_clamped = 1'b1;
                            end else begin
                                acc_nxt.wscale = bus.opt_val0[3:0];
                            end
                        end
                    end
                    8'd4: begin
                        if (bus.opt_len != 8'd2 || acc_q.sack_ok) acc_nxt.error = 1'b1;
                        else                                      acc_nxt.sack_ok = 1'b1;
                    end
                    8'd8: begin
                        if (bus.opt_len != 8'd10 || acc_q.ts_present) begin
                            acc_nxt.error = 1'b1;
                        end else begin
                            acc_nxt.ts_present = 1'b1;
                            acc_nxt.tsval      = bus.opt_val0;
                            acc_nxt.tsecr      = bus.opt_val1;
                        end
                    end
                    default: begin
                        if (acc_q.unknown_cnt != '1) acc_nxt.unknown_cnt = acc_q.unknown_cnt + 1'b1;
                    end
                endcase
            end
            if (bus.opt_last) state_nxt = EMIT;
        end
    end

    assign bus.opt_ready       = ready_q && (state_q == COLLECT);
    assign bus.sum_valid       = (state_q == EMIT);
    assign bus.sum_mss         = acc_q.mss;
    assign bus.sum_wscale      = acc_q.wscale;
    assign bus.sum_ws_present  = acc_q.ws_present;
    assign bus.sum_sack_ok     = acc_q.sack_ok;
    assign bus.sum_ts_present  = acc_q.ts_present;
    assign bus.sum_tsval       = acc_q.tsval;
    assign bus.sum_tsecr       = acc_q.tsecr;
    assign bus.sum_ws_clamped  = acc_q.ws_clamped;
    assign bus.sum_unknown_cnt = acc_q.unknown_cnt;
    assign bus.sum_error       = acc_q.error;
endmodule

// File: tb/tb_options_summary_builder.sv
// Drives directed and random option-record segments into options_summary_builder and
// compares each summary with a list-based reference model.
module tb_options_summary_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    options_summary_builder_if #(.UNK_CNT_W(4)) bus();

    options_summary_builder #(
        .DEFAULT_MSS(536),
        .MAX_WSCALE (14),
        .UNK_CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam int UNK_MAX = 15;

    typedef struct {
        logic [7:0]  kind;
        logic [7:0]  len;
        logic [31:0] v0;
        logic [31:0] v1;
        bit          err;
    } rec_t;

    typedef struct {
        int          mss;
        int          wscale;
        bit          ws_present;
        bit          ws_clamped;
        bit          sack_ok;
        bit          ts_present;
        bit          error;
        logic [31:0] tsval;
        logic [31:0] tsecr;
        int          unk;
    } sum_t;

    int   checks   = 0;
    int   failures = 0;
    rec_t seg[$];
    sum_t expv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int req_len(input logic [7:0] k);
        case (k)
            8'd2:    return 4;
            8'd3:    return 3;
            8'd4:    return 2;
            8'd8:    return 10;
            default: return -1;
        endcase
    endfunction

    function automatic rec_t mk(input int k, input int l, input logic [31:0] v0,
                                input logic [31:0] v1, input bit err);
        rec_t r;
        r.kind = 8'(k); r.len = 8'(l); r.v0 = v0; r.v1 = v1; r.err = err;
        return r;
    endfunction

    // Walk the record list: first valid instance of each known kind wins, everything else flags error.
    function automatic sum_t model();
        sum_t s;
        bit   seen [int];
        s.mss = 536; s.wscale = 0; s.ws_present = 0; s.ws_clamped = 0; s.sack_ok = 0;
        s.ts_present = 0; s.error = 0; s.tsval = 0; s.tsecr = 0; s.unk = 0;
        foreach (seg[i]) begin
            rec_t r;
            r = seg[i];
            if (r.err) begin
                s.error = 1;
            end else if (r.kind > 8'd1) begin
                if (req_len(r.kind) < 0) begin
                    s.unk = (s.unk < UNK_MAX) ? s.unk + 1 : UNK_MAX;
                end else if (int'(r.len) != req_len(r.kind) || seen.exists(int'(r.kind))) begin
                    s.error = 1;
                end else begin
                    seen[int'(r.kind)] = 1;
                    case (r.kind)
                        8'd2: s.mss = int'(r.v0[15:0]);
                        8'd3: begin
                            s.ws_present = 1;
                            s.ws_clamped = (r.v0[7:0] > 8'd14);
                            s.wscale     = s.ws_clamped ? 14 : int'(r.v0[7:0]);
                        end
                        8'd4: s.sack_ok = 1;
                        default: begin
                            s.ts_present = 1;
                            s.tsval      = r.v0;
                            s.tsecr      = r.v1;
                        end
                    endcase
                end
            end
        end
        return s;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        int   sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: r.kind = 8'd0;
            1: r.kind = 8'd1;
            2: r.kind = 8'd2;
            3: r.kind = 8'd3;
            4: r.kind = 8'd4;
            5, 6: r.kind = 8'd8;
            default: begin
                do r.kind = 8'($urandom_range(5, 255)); while (r.kind == 8'd8);
            end
        endcase
        if (r.kind <= 8'd1) r.len = 8'd0;
        else if (req_len(r.kind) >= 0 && $urandom_range(0, 7) != 0) r.len = 8'(req_len(r.kind));
        else r.len = 8'($urandom_range(0, 255));
        r.v0 = $urandom;
        if (r.kind == 8'd3) r.v0[7:0] = 8'($urandom_range(0, 20));
        r.v1  = $urandom;
        r.err = ($urandom_range(0, 15) == 0);
        return r;
    endfunction

    task automatic check_summary(input string tag);
        chk({tag, ".mss"},        bus.sum_mss,         expv.mss);
        chk({tag, ".wscale"},     bus.sum_wscale,      expv.wscale);
        chk({tag, ".ws_present"}, bus.sum_ws_present,  expv.ws_present);
        chk({tag, ".ws_clamped"}, bus.sum_ws_clamped,  expv.ws_clamped);
        chk({tag, ".sack_ok"},    bus.sum_sack_ok,     expv.sack_ok);
        chk({tag, ".ts_present"}, bus.sum_ts_present,  expv.ts_present);
        chk({tag, ".tsval"},      bus.sum_tsval,       expv.tsval);
        chk({tag, ".tsecr"},      bus.sum_tsecr,       expv.tsecr);
        chk({tag, ".unknown"},    bus.sum_unknown_cnt, expv.unk);
        chk({tag, ".error"},      bus.sum_error,       expv.error);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".sum_valid"}, bus.sum_valid, 0);
        chk({tag, ".opt_ready"}, bus.opt_ready, 0);
        chk({tag, ".mss"},       bus.sum_mss, 536);
        chk({tag, ".others"},    {bus.sum_wscale, bus.sum_ws_present, bus.sum_sack_ok, bus.sum_ts_present,
                                  bus.sum_ws_clamped, bus.sum_unknown_cnt, bus.sum_error}, 0);
        chk({tag, ".ts"},        {bus.sum_tsval, bus.sum_tsecr}, 0);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_rec(input rec_t r, input bit last);
        int budget;
        if ($urandom_range(0, 3) == 0) begin
            bus.opt_valid = 1'b0; bus.opt_kind = 8'd2; bus.opt_len = 8'd4;
            bus.opt_val0 = $urandom; bus.opt_last = 1'b1; bus.opt_err = 1'b1;
            @(negedge clk);
        end
        bus.opt_valid = 1'b1; bus.opt_kind = r.kind; bus.opt_len = r.len;
        bus.opt_val0 = r.v0;  bus.opt_val1 = r.v1;  bus.opt_last = last; bus.opt_err = r.err;
        budget = 0;
        while (!bus.opt_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 50) begin
                chk("accept_timeout", 0, 1);
                bus.opt_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.opt_valid = 1'b0;
    endtask

    task automatic push_segment(input string tag);
        expv = model();
        foreach (seg[i]) send_rec(seg[i], i == seg.size() - 1);
        chk({tag, ".sum_valid"}, bus.sum_valid, 1);
        chk({tag, ".ready_emit"}, bus.opt_ready, 0);
        check_summary(tag);
    endtask

    task automatic finish_segment(input string tag, input int hold);
        for (int c = 0; c < hold; c++) begin
            bus.opt_valid = 1'($urandom_range(0, 1));
            bus.opt_kind = 8'd2; bus.opt_len = 8'd4; bus.opt_val0 = $urandom;
            bus.opt_last = 1'b1; bus.opt_err = 1'b0;
            @(negedge clk);
            chk({tag, ".hold_valid"}, bus.sum_valid, 1);
            chk({tag, ".hold_ready"}, bus.opt_ready, 0);
            check_summary({tag, ".hold"});
        end
        bus.sum_ready = 1'b1;
        @(negedge clk);
        bus.sum_ready = 1'b0;
        bus.opt_valid = 1'b0;
        chk({tag, ".post_valid"}, bus.sum_valid, 0);
        chk({tag, ".post_ready"}, bus.opt_ready, 1);
        chk({tag, ".post_mss"},   bus.sum_mss, 536);
    endtask

    task automatic run_segment(input string tag, input int hold);
        push_segment(tag);
        finish_segment(tag, hold);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, ".ready_after"}, bus.opt_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opt_valid = 1'b0; bus.opt_kind = 8'd0; bus.opt_len = 8'd0; bus.opt_val0 = 32'd0;
        bus.opt_val1 = 32'd0; bus.opt_last = 1'b0; bus.opt_err = 1'b0; bus.sum_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ready_after", bus.opt_ready, 1);

        seg = '{mk(2, 4, 1460, 0, 0), mk(3, 3, 7, 0, 0), mk(4, 2, 0, 0, 0),
                mk(8, 10, 32'h11223344, 32'h55667788, 0)};
        push_segment("t1");
        chk("t1.mss_const", bus.sum_mss, 1460);
        finish_segment("t1", 0);

        seg = '{mk(0, 0, 0, 0, 0)};
        run_segment("t2", 0);

        seg = '{mk(3, 3, 20, 0, 0), mk(2, 3, 1200, 0, 0)};
        push_segment("t3");
        chk("t3.clamp_const", {bus.sum_wscale, bus.sum_ws_clamped, bus.sum_error}, {4'd14, 1'b1, 1'b1});
        finish_segment("t3", 0);

        seg = '{mk(2, 4, 1000, 0, 0), mk(2, 4, 500, 0, 0)};
        for (int i = 0; i < 17; i++) seg.push_back(mk(30, 2, 0, 0, 0));
        push_segment("t4");
        chk("t4.unk_const", bus.sum_unknown_cnt, 15);
        finish_segment("t4", 0);

        seg = '{mk(8, 10, 32'hdeadbeef, 32'hcafef00d, 0), mk(4, 2, 0, 0, 0), mk(1, 0, 0, 0, 0)};
        run_segment("t5", 5);
        seg = '{mk(0, 0, 0, 0, 0)};
        run_segment("t5.next", 0);

        seg = '{mk(2, 4, 777, 0, 0), mk(3, 3, 9, 0, 0)};
        push_segment("t6a");
        pulse_reset("t6a.rst");
        seg = '{mk(0, 0, 0, 0, 0)};
        run_segment("t6a.next", 0);

        send_rec(mk(2, 4, 1234, 0, 0), 1'b0);
        send_rec(mk(8, 10, 32'h1, 32'h2, 0), 1'b0);
        pulse_reset("t6b.rst");
        seg = '{mk(0, 0, 0, 0, 0)};
        run_segment("t6b.next", 0);

        seg = '{mk(2, 4, 900, 0, 1), mk(4, 2, 0, 0, 0)};
        run_segment("err_rec", 1);

        for (int n = 0; n < 60; n++) begin
            int cnt;
            seg.delete();
            cnt = $urandom_range(1, 8);
            for (int i = 0; i < cnt; i++) seg.push_back(rand_rec());
            run_segment("rand", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
